// File: rtl/clock_phase_sequencer.sv
// Four-phase instruction sequencer: one-cycle clock-enable strobes for FETCH/EXEC/MEM/WB,
// programmable phase length, post-reset startup delay and a debug halt/single-step handshake.
module clock_phase_sequencer #(
    parameter int DIV_W          = 8,
    parameter int STARTUP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             halt,
    input  logic             step,
    output logic             imem_en,
    output logic             proc_en,
    output logic             dmem_en,
    output logic             regfile_en,
    output logic             cycle_done,
    output logic [1:0]       phase,
    output logic             running,
    output logic [31:0]      instr_count
);

    localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

    localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [SU_W-1:0]  SU_ONE   = SU_W'(1);
    localparam logic [SU_W-1:0]  SU_ZERO  = {SU_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

    localparam logic [1:0] PH_FETCH = 2'd0;
    localparam logic [1:0] PH_EXEC  = 2'd1;
    localparam logic [1:0] PH_MEM   = 2'd2;
    localparam logic [1:0] PH_WB    = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_RUN        = 2'd1,
        ST_HALTED     = 2'd2,
        ST_STEP       = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [SU_W-1:0]  su_cnt_r;
    logic [SU_W-1:0]  su_cnt_s;
    logic [DIV_W-1:0] ph_cnt_r;
    logic [DIV_W-1:0] ph_cnt_s;
    logic [DIV_W-1:0] div_q_r;
    logic [DIV_W-1:0] div_q_s;
    logic [1:0]       phase_r;
    logic [1:0]       phase_s;
    logic [31:0]      instr_count_r;
    logic [31:0]      instr_count_s;

    logic             imem_en_r;
    logic             proc_en_r;
    logic             dmem_en_r;
    logic             regfile_en_r;
    logic             cycle_done_r;
    logic             running_r;
    logic             imem_en_s;
    logic             proc_en_s;
    logic             dmem_en_s;
    logic             regfile_en_s;
    logic             cycle_done_s;
    logic             running_s;

    logic             start_s;
    logic             last_s;
    logic             active_s;
    logic             boundary_s;

    assign last_s     = (ph_cnt_r == div_q_r);
    assign active_s   = (state_r == ST_RUN) || (state_r == ST_STEP);
    assign boundary_s = active_s && (phase_r == PH_WB) && last_s;

    // Next-state, phase counter, latched divider and instruction counter.
    always_comb begin
        state_s       = state_r;
        su_cnt_s      = su_cnt_r;
        ph_cnt_s      = ph_cnt_r;
        div_q_s       = div_q_r;
        phase_s       = phase_r;
        instr_count_s = instr_count_r;
        start_s       = 1'b0;
        case (state_r)
            ST_RESET_WAIT: begin
                if (su_cnt_r == SU_LAST) begin
                    state_s  = ST_RUN;
                    su_cnt_s = SU_ZERO;
                    phase_s  = PH_FETCH;
                    start_s  = 1'b1;
                end else begin
                    su_cnt_s = su_cnt_r + SU_ONE;
                end
            end
            ST_RUN, ST_STEP: begin
                if (boundary_s) begin
                    instr_count_s = instr_count_r + 32'd1;
                    phase_s       = PH_FETCH;
                    // A stepped instruction always parks again; halt only matters in RUN.
                    if ((state_r == ST_STEP) || halt) begin
                        state_s  = ST_HALTED;
                        ph_cnt_s = DIV_ZERO;
                    end else begin
                        start_s = 1'b1;
                    end
                end else if (last_s) begin
                    phase_s = phase_r + 2'd1;
                    start_s = 1'b1;
                end else begin
                    ph_cnt_s = ph_cnt_r + DIV_ONE;
                end
            end
            ST_HALTED: begin
                // Release has priority over a simultaneous step pulse.
                if (!halt) begin
                    state_s = ST_RUN;
                    phase_s = PH_FETCH;
                    start_s = 1'b1;
                end else if (step) begin
                    state_s = ST_STEP;
                    phase_s = PH_FETCH;
                    start_s = 1'b1;
                end else begin
                    phase_s  = PH_FETCH;
                    ph_cnt_s = DIV_ZERO;
                end
            end
            default: begin
                state_s  = ST_RESET_WAIT;
                su_cnt_s = SU_ZERO;
                ph_cnt_s = DIV_ZERO;
                phase_s  = PH_FETCH;
            end
        endcase
        if (start_s) begin
            ph_cnt_s = DIV_ZERO;
            div_q_s  = div_sel;
        end else begin
            div_q_s  = div_q_r;
        end
    end

    // Output values for the cycle that follows the next clock edge.
    always_comb begin
        imem_en_s    = 1'b0;
        proc_en_s    = 1'b0;
        dmem_en_s    = 1'b0;
        regfile_en_s = 1'b0;
        running_s    = (state_s == ST_RUN) || (state_s == ST_STEP);
        cycle_done_s = running_s && (phase_s == PH_WB) && (ph_cnt_s == div_q_s);
        if (start_s) begin
            case (phase_s)
                PH_FETCH: imem_en_s    = 1'b1;
                PH_EXEC:  proc_en_s    = 1'b1;
                PH_MEM:   dmem_en_s    = 1'b1;
                PH_WB:    regfile_en_s = 1'b1;
                default:  imem_en_s    = 1'b0;
            endcase
        end else begin
            imem_en_s = 1'b0;
        end
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_RESET_WAIT;
            su_cnt_r      <= SU_ZERO;
            ph_cnt_r      <= DIV_ZERO;
            div_q_r       <= DIV_ZERO;
            phase_r       <= PH_FETCH;
            instr_count_r <= 32'd0;
            imem_en_r     <= 1'b0;
            proc_en_r     <= 1'b0;
            dmem_en_r     <= 1'b0;
            regfile_en_r  <= 1'b0;
            cycle_done_r  <= 1'b0;
            running_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            su_cnt_r      <= su_cnt_s;
            ph_cnt_r      <= ph_cnt_s;
            div_q_r       <= div_q_s;
            phase_r       <= phase_s;
            instr_count_r <= instr_count_s;
            imem_en_r     <= imem_en_s;
            proc_en_r     <= proc_en_s;
            dmem_en_r     <= dmem_en_s;
            regfile_en_r  <= regfile_en_s;
            cycle_done_r  <= cycle_done_s;
            running_r     <= running_s;
        end
    end

    assign imem_en     = imem_en_r;
    assign proc_en     = proc_en_r;
    assign dmem_en     = dmem_en_r;
    assign regfile_en  = regfile_en_r;
    assign cycle_done  = cycle_done_r;
    assign phase       = phase_r;
    assign running     = running_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_clock_phase_sequencer.sv
// Directed self-checking bench for clock_phase_sequencer: startup, divide, halt, step,
// release/step collision, counter wrap and mid-instruction reset.
module tb_clock_phase_sequencer;

    logic        clk;
    logic        resetn;
    logic [7:0]  div_sel;
    logic        halt;
    logic        step;
    logic        imem_en;
    logic        proc_en;
    logic        dmem_en;
    logic        regfile_en;
    logic        cycle_done;
    logic [1:0]  phase;
    logic        running;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    clock_phase_sequencer #(.DIV_W(8), .STARTUP_CYCLES(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .div_sel     (div_sel),
        .halt        (halt),
        .step        (step),
        .imem_en     (imem_en),
        .proc_en     (proc_en),
        .dmem_en     (dmem_en),
        .regfile_en  (regfile_en),
        .cycle_done  (cycle_done),
        .phase       (phase),
        .running     (running),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {imem, proc, dmem, regfile, cycle_done}
    function automatic logic [4:0] sb();
        return {imem_en, proc_en, dmem_en, regfile_en, cycle_done};
    endfunction

    // Expected strobes in a 4-cycle (div 0) instruction, indexed by phase.
    function automatic logic [4:0] exp_div0(int p);
        case (p)
            0:       return 5'b10000;
            1:       return 5'b01000;
            2:       return 5'b00100;
            default: return 5'b00011;
        endcase
    endfunction

    task automatic test_reset();
        resetn = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({sb(), phase, running, instr_count} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=0", {sb(), phase, running, instr_count});
        end
        repeat (3) tick();
        n_checks++;
        if ({sb(), phase, running, instr_count} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=0", {sb(), phase, running, instr_count});
        end
        resetn = 1'b1;
    endtask

    task automatic test_startup();
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if ({sb(), running} !== ((k == 16) ? 6'b100001 : 6'b000000)) begin
                n_fail++;
                $display("FAIL startup k=%0d got=%b", k, {sb(), running});
            end
        end
        for (int c = 1; c < 8; c++) begin
            tick();
            n_checks++;
            if ({sb(), phase, running, instr_count} !== {exp_div0(c % 4), 2'(c % 4), 1'b1, 32'(c / 4)}) begin
                n_fail++;
                $display("FAIL div0_seq c=%0d got sb=%b ph=%0d run=%b cnt=%0d exp sb=%b cnt=%0d",
                         c, sb(), phase, running, instr_count, exp_div0(c % 4), c / 4);
            end
        end
    endtask

    task automatic test_divide();
        logic [4:0] exp_sb;
        logic [4:0] t_sb [0:8];
        logic [1:0] t_ph [0:8];
        t_sb = '{5'b10000, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00100, 5'b00011, 5'b10000};
        t_ph = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
        div_sel = 8'd2;
        for (int r = 0; r < 12; r++) begin
            tick();
            exp_sb = 5'b00000;
            if (r % 3 == 0) exp_sb[4 - r / 3] = 1'b1;
            if (r == 11) exp_sb[0] = 1'b1;
            n_checks++;
            if ({sb(), phase, instr_count} !== {exp_sb, 2'(r / 3), 32'd2}) begin
                n_fail++;
                $display("FAIL div2_seq r=%0d got sb=%b ph=%0d cnt=%0d exp sb=%b ph=%0d cnt=2",
                         r, sb(), phase, instr_count, exp_sb, r / 3);
            end
        end
        for (int r = 0; r < 9; r++) begin
            tick();
            n_checks++;
            if ({sb(), phase, instr_count} !== {t_sb[r], t_ph[r], ((r < 8) ? 32'd3 : 32'd4)}) begin
                n_fail++;
                $display("FAIL div_change r=%0d got sb=%b ph=%0d cnt=%0d exp sb=%b ph=%0d",
                         r, sb(), phase, instr_count, t_sb[r], t_ph[r]);
            end
            if (r == 4) div_sel = 8'd0;
        end
    endtask

    task automatic test_halt();
        for (int c = 1; c < 4; c++) begin
            tick();
            n_checks++;
            if ({sb(), phase, running, instr_count} !== {exp_div0(c), 2'(c), 1'b1, 32'd4}) begin
                n_fail++;
                $display("FAIL halt_finish c=%0d got sb=%b ph=%0d run=%b cnt=%0d",
                         c, sb(), phase, running, instr_count);
            end
            if (c == 2) halt = 1'b1;
        end
        for (int k = 0; k < 21; k++) begin
            tick();
            n_checks++;
            if ({sb(), phase, running, instr_count} !== {5'b00000, 2'd0, 1'b0, 32'd5}) begin
                n_fail++;
                $display("FAIL halted k=%0d got sb=%b ph=%0d run=%b cnt=%0d exp sb=0 ph=0 run=0 cnt=5",
                         k, sb(), phase, running, instr_count);
            end
        end
    endtask

    task automatic test_step();
        step = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            step = (c == 0) ? 1'b1 : 1'b0;
            n_checks++;
            if ({sb(), phase, running, instr_count} !== {exp_div0(c), 2'(c), 1'b1, 32'd5}) begin
                n_fail++;
                $display("FAIL step_seq c=%0d got sb=%b ph=%0d run=%b cnt=%0d",
                         c, sb(), phase, running, instr_count);
            end
        end
        step = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if ({sb(), phase, running, instr_count} !== {5'b00000, 2'd0, 1'b0, 32'd6}) begin
                n_fail++;
                $display("FAIL step_rehalt k=%0d got sb=%b ph=%0d run=%b cnt=%0d exp cnt=6",
                         k, sb(), phase, running, instr_count);
            end
        end
    endtask

    task automatic test_release_collision();
        halt = 1'b0;
        step = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            step = 1'b0;
            n_checks++;
            if ({sb(), phase, running, instr_count} !== {exp_div0(c % 4), 2'(c % 4), 1'b1, 32'(6 + c / 4)}) begin
                n_fail++;
                $display("FAIL release_run c=%0d got sb=%b ph=%0d run=%b cnt=%0d exp sb=%b cnt=%0d",
                         c, sb(), phase, running, instr_count, exp_div0(c % 4), 6 + c / 4);
            end
        end
    endtask

    task automatic test_wrap();
        force dut.instr_count_r = 32'hFFFF_FFFF;
        tick();
        tick();
        release dut.instr_count_r;
        n_checks++;
        if ({sb(), instr_count} !== {5'b00100, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL wrap_preload got sb=%b cnt=%h exp sb=00100 cnt=ffffffff", sb(), instr_count);
        end
        tick();
        n_checks++;
        if ({sb(), instr_count} !== {5'b00011, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL wrap_wb got sb=%b cnt=%h exp sb=00011 cnt=ffffffff", sb(), instr_count);
        end
        tick();
        n_checks++;
        if ({sb(), instr_count} !== {5'b10000, 32'd0}) begin
            n_fail++;
            $display("FAIL wrap_zero got sb=%b cnt=%h exp sb=10000 cnt=0", sb(), instr_count);
        end
    endtask

    task automatic test_reset_midop();
        tick();
        n_checks++;
        if ({sb(), phase, instr_count} !== {5'b01000, 2'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL midop_exec got sb=%b ph=%0d cnt=%0d exp sb=01000 ph=1 cnt=0", sb(), phase, instr_count);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({sb(), phase, running, instr_count} !== 40'd0) begin
            n_fail++;
            $display("FAIL midop_async got=%h exp=0", {sb(), phase, running, instr_count});
        end
        tick();
        tick();
        resetn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if ({sb(), phase, running, instr_count} !== {((k == 16) ? 5'b10000 : 5'b00000), 2'd0, (k == 16) ? 1'b1 : 1'b0, 32'd0}) begin
                n_fail++;
                $display("FAIL restart k=%0d got sb=%b ph=%0d run=%b cnt=%0d",
                         k, sb(), phase, running, instr_count);
            end
        end
    endtask

    initial begin
        div_sel = 8'd0;
        halt    = 1'b0;
        step    = 1'b0;
        resetn  = 1'b1;
        test_reset();
        test_startup();
        test_divide();
        test_halt();
        test_step();
        test_release_collision();
        test_wrap();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
